// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Single-outstanding instruction fetch unit. It accepts a fetch address from
//   the program counter, issues one read to instruction memory, waits for the
//   in-order response and holds the instruction for decode until it is taken.
//   The flush input abandons the current fetch at any point. A response that is
//   still owed by memory for an abandoned request is absorbed in DROP.
//
// Configuration macro:
//   FETCH_MISALIGN_CHECK_EN - when defined, a fetch address with bits [1:0] != 0
//                             is not sent to memory. A faulting instruction
//                             (o_fault=1, o_instr=0) is presented instead.
//                             When undefined, o_fault is tied 0.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_pc, i_pc_valid  fetch address from the PC; o_pc_ready accepts it (IDLE only)
//   o_imem_req/addr   memory read request, held until i_imem_gnt
//   i_imem_rvalid/rdata  in-order read response, one per grant
//   o_instr, o_instr_pc, o_fault, o_instr_valid  instruction to decode
//   i_instr_ready     decode consumes the held instruction
//   i_flush           discard the in-flight fetch and the held instruction
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int unsigned                  DATA_WIDTH_P = 32,
  parameter logic [DATA_WIDTH_P-1:0]      RESET_PC_P   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH_P-1:0] i_pc,
  input  logic                    i_pc_valid,
  output logic                    o_pc_ready,
  output logic                    o_imem_req,
  output logic [DATA_WIDTH_P-1:0] o_imem_addr,
  input  logic                    i_imem_gnt,
  input  logic                    i_imem_rvalid,
  input  logic [DATA_WIDTH_P-1:0] i_imem_rdata,
  output logic [DATA_WIDTH_P-1:0] o_instr,
  output logic [DATA_WIDTH_P-1:0] o_instr_pc,
  output logic                    o_instr_valid,
  input  logic                    i_instr_ready,
  output logic                    o_fault,
  input  logic                    i_flush
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH_P-1:0] fetch_addr;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

  // The request address is the captured fetch address, so it cannot move
  // while a request is pending.
  assign o_imem_addr = fetch_addr;

  // Fetch sequencer. All outputs are registered. o_pc_ready is set exactly on
  // the transitions into IDLE, which keeps i_instr_ready out of any
  // combinational path to o_pc_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      fetch_addr    <= RESET_PC_P;
      o_pc_ready    <= 1'b1;
      o_imem_req    <= 1'b0;
      o_instr       <= '0;
      o_instr_pc    <= RESET_PC_P;
      o_instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Flush wins over a same-cycle capture; nothing is in flight here.
          if (i_flush) begin
            o_instr_valid <= 1'b0;
          end else if (i_pc_valid) begin
            fetch_addr <= i_pc;
            o_pc_ready <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (i_pc[1:0] != 2'b00) begin
              // Misaligned: present a fault without touching memory.
              state         <= HOLD;
              o_instr       <= '0;
              o_instr_pc    <= i_pc;
              o_instr_valid <= 1'b1;
              fault_q       <= 1'b1;
            end else begin
              state      <= REQ;
              o_imem_req <= 1'b1;
            end
`else
            state      <= REQ;
            o_imem_req <= 1'b1;
`endif
          end
        end

        REQ: begin
          if (i_imem_gnt) begin
            // A granted request owes a response; a flush must absorb it.
            o_imem_req <= 1'b0;
            state      <= i_flush ? DROP : WAIT;
          end else if (i_flush) begin
            o_imem_req <= 1'b0;
            o_pc_ready <= 1'b1;
            state      <= IDLE;
          end
        end

        WAIT: begin
          if (i_imem_rvalid) begin
            if (i_flush) begin
              o_pc_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              o_instr       <= i_imem_rdata;
              o_instr_pc    <= fetch_addr;
              o_instr_valid <= 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
              fault_q       <= 1'b0;
`endif
              state         <= HOLD;
            end
          end else if (i_flush) begin
            state <= DROP;
          end
        end

        HOLD: begin
          // o_instr_valid is always 1 here, so i_instr_ready alone completes
          // the handshake; flush ends it the same way.
          if (i_flush || i_instr_ready) begin
            o_instr_valid <= 1'b0;
            o_pc_ready    <= 1'b1;
            state         <= IDLE;
          end
        end

        DROP: begin
          // The owed response ends the drop; further flushes just wait here.
          if (i_imem_rvalid) begin
            o_pc_ready <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          o_pc_ready    <= 1'b1;
          o_imem_req    <= 1'b0;
          o_instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. Directed scenarios plus a
//   randomized run whose expected instructions come from a transaction-level
//   model: a fetch of address A answered with data D yields {D, A, fault=0};
//   a misaligned address with the check enabled yields {0, A, fault=1}.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fault;
  logic        flush;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch #(
    .DATA_WIDTH_P(32),
    .RESET_PC_P  (RESET_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_pc         (pc),
    .i_pc_valid   (pc_valid),
    .o_pc_ready   (pc_ready),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (imem_gnt),
    .i_imem_rvalid(imem_rvalid),
    .i_imem_rdata (imem_rdata),
    .o_instr      (instr),
    .o_instr_pc   (instr_pc),
    .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready),
    .o_fault      (fault),
    .i_flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b exp 0", fault); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h exp 0", instr); end
    n_cmp++; if (instr_pc !== RESET_PC) begin n_err++; $display("FAIL reset_instr_pc: got %h exp %h", instr_pc, RESET_PC); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h exp %h", imem_addr, RESET_PC); end
    n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL reset_pc_ready: got %b exp 1", pc_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    pc = 32'h100; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL basic_pc_ready_req: got %b exp 0", pc_ready); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req: got %b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL basic_addr: got %h exp 100", imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop: got %b exp 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_wait: got %b exp 0", instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; instr_ready = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b exp 1", instr_valid); end
    n_cmp++; if (instr !== 32'h0050_0093) begin n_err++; $display("FAIL basic_instr: got %h exp 00500093", instr); end
    n_cmp++; if (instr_pc !== 32'h100) begin n_err++; $display("FAIL basic_instr_pc: got %h exp 100", instr_pc); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL basic_fault: got %b exp 0", fault); end
    tick();
    instr_ready = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_once: got %b exp 0", instr_valid); end
    n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL basic_pc_ready_back: got %b exp 1", pc_ready); end
  endtask

  task automatic test_backpressure();
    pc = 32'h180; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA5A5_1234;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, instr_valid); end
      n_cmp++; if (instr !== 32'hA5A5_1234) begin n_err++; $display("FAIL bp_instr[%0d]: got %h exp a5a51234", i, instr); end
      n_cmp++; if (instr_pc !== 32'h180) begin n_err++; $display("FAIL bp_instr_pc[%0d]: got %h exp 180", i, instr_pc); end
      n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL bp_pc_ready[%0d]: got %b exp 0", i, pc_ready); end
      pc_valid = (i == 2); pc = 32'h999;
      tick();
    end
    pc_valid = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b exp 0", instr_valid); end
    n_cmp++; if (imem_addr !== 32'h180) begin n_err++; $display("FAIL bp_pc_ignored: got %h exp 180", imem_addr); end
    tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_no_new_req: got %b exp 0", imem_req); end
  endtask

  task automatic test_mem_stall();
    pc = 32'h104; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_req[%0d]: got %b exp 1", i, imem_req); end
      n_cmp++; if (imem_addr !== 32'h104) begin n_err++; $display("FAIL stall_addr[%0d]: got %h exp 104", i, imem_addr); end
      imem_gnt = (i == 3);
      tick();
    end
    imem_gnt = 1'b0;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req_drop: got %b exp 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (instr !== 32'h13 || instr_pc !== 32'h104) begin n_err++; $display("FAIL stall_result: got %h@%h exp 00000013@104", instr, instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_flush_wait();
    pc = 32'h1F0; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL fw_valid_drop: got %b exp 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL fw_req_drop: got %b exp 0", imem_req); end
    n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL fw_pc_ready_drop: got %b exp 0", pc_ready); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL fw_discard: got %b exp 0", instr_valid); end
    n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL fw_idle: got %b exp 1", pc_ready); end
    pc = 32'h200; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL fw_next_req: got %b@%h exp 1@200", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h200) begin
      n_err++; $display("FAIL fw_next_data: got v=%b %h@%h exp v=1 00a00113@200", instr_valid, instr, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_flush_other();
    // Flush in REQ without grant withdraws the request.
    pc = 32'h300; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (imem_req !== 1'b0 || pc_ready !== 1'b1) begin n_err++; $display("FAIL fr_withdraw: got req=%b rdy=%b exp req=0 rdy=1", imem_req, pc_ready); end
    // Flush in WAIT coincident with the response.
    pc = 32'h304; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    flush = 1'b0; imem_rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin n_err++; $display("FAIL fwr_discard: got v=%b rdy=%b exp v=0 rdy=1", instr_valid, pc_ready); end
    // Flush in HOLD together with ready.
    pc = 32'h308; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_4444;
    tick();
    imem_rvalid = 1'b0; flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin n_err++; $display("FAIL fh_clear: got v=%b rdy=%b exp v=0 rdy=1", instr_valid, pc_ready); end
    // Flush in REQ with grant, then a second flush while dropping.
    pc = 32'h30C; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1; flush = 1'b1;
    tick();
    imem_gnt = 1'b0;
    n_cmp++; if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL fg_drop: got rdy=%b req=%b exp rdy=0 req=0", pc_ready, imem_req); end
    tick();
    flush = 1'b0;
    n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL fg_drop_stay: got %b exp 0", pc_ready); end
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_6666;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (pc_ready !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL fg_absorb: got rdy=%b v=%b exp rdy=1 v=0", pc_ready, instr_valid); end
  endtask

  task automatic test_async_reset();
    pc = 32'h400; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    // Now in WAIT; assert reset between edges.
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL ar_pc_ready: got %b exp 1", pc_ready); end
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
      n_err++; $display("FAIL ar_flags: got req=%b v=%b f=%b exp 0/0/0", imem_req, instr_valid, fault);
    end
    n_cmp++; if (instr !== 32'h0 || instr_pc !== RESET_PC || imem_addr !== RESET_PC) begin
      n_err++; $display("FAIL ar_data: got %h@%h addr=%h exp 0@%h addr=%h", instr, instr_pc, imem_addr, RESET_PC, RESET_PC);
    end
    #1 reset = 1'b0;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_8888;
    tick();
    imem_rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin n_err++; $display("FAIL ar_stray: got v=%b rdy=%b exp v=0 rdy=1", instr_valid, pc_ready); end
  endtask

  task automatic test_misalign();
    pc = 32'h102; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    if (CHECK_EN) begin
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL ma_no_req: got %b exp 0", imem_req); end
      n_cmp++; if (instr_valid !== 1'b1 || fault !== 1'b1) begin n_err++; $display("FAIL ma_fault: got v=%b f=%b exp 1/1", instr_valid, fault); end
      n_cmp++; if (instr !== 32'h0 || instr_pc !== 32'h102) begin n_err++; $display("FAIL ma_data: got %h@%h exp 0@102", instr, instr_pc); end
    end else begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h102) begin n_err++; $display("FAIL ma_fetch: got %b@%h exp 1@102", imem_req, imem_addr); end
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_rvalid = 1'b0;
      n_cmp++; if (fault !== 1'b0 || instr !== 32'h1234_5678 || instr_pc !== 32'h102) begin
        n_err++; $display("FAIL ma_plain: got f=%b %h@%h exp f=0 12345678@102", fault, instr, instr_pc);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin n_err++; $display("FAIL ma_release: got v=%b rdy=%b exp 0/1", instr_valid, pc_ready); end
  endtask

  task automatic test_random();
    logic [31:0] addr, data, exp_instr;
    logic        exp_fault;
    int          gnt_dly, lat, rdy_dly;
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < 10 && pc_ready !== 1'b1; k++) tick();
      n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL rnd_ready_timeout[%0d]: got %b exp 1", t, pc_ready); end
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3, 0) == 0) addr[1:0] = 2'($urandom_range(3, 1));
      data      = $urandom;
      gnt_dly   = (t < 5) ? 0 : int'($urandom_range(3, 0));
      lat       = (t < 5) ? 1 : int'($urandom_range(3, 1));
      rdy_dly   = (t < 5) ? 0 : int'($urandom_range(3, 0));
      exp_fault = CHECK_EN && (addr[1:0] != 2'b00);
      exp_instr = exp_fault ? 32'h0 : data;
      pc = addr; pc_valid = 1'b1;
      tick();
      if (!exp_fault) begin
        for (int i = 0; i <= gnt_dly; i++) begin
          n_cmp++; if (imem_req !== 1'b1 || imem_addr !== addr) begin
            n_err++; $display("FAIL rnd_req[%0d]: got %b@%h exp 1@%h", t, imem_req, imem_addr, addr);
          end
          pc_valid = 1'($urandom); pc = $urandom;
          imem_gnt = (i == gnt_dly);
          tick();
        end
        imem_gnt = 1'b0;
        for (int i = 1; i <= lat; i++) begin
          n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL rnd_wait[%0d]: got v=%b req=%b exp 0/0", t, instr_valid, imem_req);
          end
          pc_valid = 1'($urandom); pc = $urandom;
          imem_rvalid = (i == lat); imem_rdata = (i == lat) ? data : $urandom;
          tick();
        end
        imem_rvalid = 1'b0;
      end else begin
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rnd_fault_req[%0d]: got %b exp 0", t, imem_req); end
      end
      for (int i = 0; i <= rdy_dly; i++) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr !== exp_instr || instr_pc !== addr || fault !== exp_fault || pc_ready !== 1'b0) begin
          n_err++; $display("FAIL rnd_hold[%0d.%0d]: got v=%b %h@%h f=%b rdy=%b exp v=1 %h@%h f=%b rdy=0",
                            t, i, instr_valid, instr, instr_pc, fault, pc_ready, exp_instr, addr, exp_fault);
        end
        pc_valid = 1'($urandom); pc = $urandom;
        instr_ready = (i == rdy_dly);
        tick();
      end
      instr_ready = 1'b0; pc_valid = 1'b0;
      // Back in IDLE immediately after the handshake: no bubble.
      n_cmp++; if (instr_valid !== 1'b0 || pc_ready !== 1'b1) begin
        n_err++; $display("FAIL rnd_done[%0d]: got v=%b rdy=%b exp 0/1", t, instr_valid, pc_ready);
      end
    end
  endtask

  initial begin
    reset = 1'b1; pc = '0; pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_mem_stall();
    test_flush_wait();
    test_flush_other();
    test_async_reset();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish exp finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DATA_WIDTH_P, default 32: width of addresses, instruction words and fetch-address registers.
REQ-002 Parameter RESET_PC_P, default 0: value of o_instr_pc after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_pc  input  DATA_WIDTH_P  fetch address driven by the program counter.
REQ-006 i_pc_valid  input  1  i_pc holds a new fetch address.
REQ-007 o_pc_ready  output  1  block accepts i_pc this cycle.
REQ-008 o_imem_req  output  1  instruction-memory read request.
REQ-009 o_imem_addr  output  DATA_WIDTH_P  address of the request.
REQ-010 i_imem_gnt  input  1  memory accepts the request this cycle.
REQ-011 i_imem_rvalid  input  1  read data valid, one pulse per granted request, in order.
REQ-012 i_imem_rdata  input  DATA_WIDTH_P  read data.
REQ-013 o_instr  output  DATA_WIDTH_P  fetched instruction to decode.
REQ-014 o_instr_pc  output  DATA_WIDTH_P  address o_instr was fetched from.
REQ-015 o_instr_valid  output  1  o_instr, o_instr_pc and o_fault are valid.
REQ-016 i_instr_ready  input  1  decode consumes the instruction this cycle.
REQ-017 o_fault  output  1  misaligned-fetch fault flag.
REQ-018 i_flush  input  1  discard in-flight fetch and the held instruction.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and DROP.
REQ-020 IDLE: o_pc_ready=1; i_pc_valid captures i_pc into the fetch-address register -> REQ.
REQ-021 REQ: o_imem_req=1 and o_imem_addr=captured address, both stable until i_imem_gnt; gnt -> WAIT.
REQ-022 WAIT: i_imem_rvalid loads o_instr<=i_imem_rdata and o_instr_pc<=fetch address, and sets o_instr_valid -> HOLD. rvalid in the same cycle as gnt is not permitted; response latency is 1 or more cycles after gnt, unbounded.
REQ-023 HOLD: o_instr, o_instr_pc and o_fault SHALL stay stable while o_instr_valid=1 and i_instr_ready=0.
REQ-024 HOLD: o_instr_valid & i_instr_ready clears o_instr_valid -> IDLE; o_pc_ready is 0 in every state except IDLE.
REQ-025 Outside IDLE, i_pc and i_pc_valid SHALL be ignored.
REQ-026 Flush in IDLE or HOLD: o_instr_valid cleared next cycle -> IDLE; in HOLD, flush takes priority over a same-cycle ready handshake.
REQ-027 Flush in REQ without gnt: request withdrawn next cycle -> IDLE.
REQ-028 Flush in REQ with gnt, or in WAIT without rvalid: -> DROP.
REQ-029 Flush in WAIT with rvalid: data discarded -> IDLE.
REQ-030 DROP: o_imem_req=0, o_instr_valid=0; next rvalid discarded -> IDLE; a further i_flush in DROP stays in DROP.
REQ-031 Steady-state throughput SHALL be one instruction per 4 cycles at 1-cycle memory latency, with no combinational path from i_instr_ready to o_pc_ready.

Reset
REQ-032 Reset SHALL force state IDLE immediately, without waiting for a clock edge.
REQ-033 Reset values: o_instr_valid=0, o_imem_req=0, o_fault=0, o_instr=0, o_instr_pc=RESET_PC_P, fetch-address register=RESET_PC_P.
REQ-034 Reset mid-fetch SHALL abandon the outstanding request; a response arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-035 Macro FETCH_MISALIGN_CHECK_EN enables the misaligned-fetch check.
REQ-036 With FETCH_MISALIGN_CHECK_EN: a captured address with bits [1:0] != 0 SHALL skip REQ/WAIT and go IDLE -> HOLD next cycle with o_fault=1, o_instr=0, o_instr_pc=that address, and no memory request.
REQ-037 Without FETCH_MISALIGN_CHECK_EN: o_fault SHALL be tied 0 and every address SHALL be fetched unchanged.

Verification
REQ-038 Basic fetch: pc=0x100, gnt same cycle, rdata=0x00500093 one cycle later, ready=1 -> o_instr=0x00500093, o_instr_pc=0x100, valid for exactly 1 cycle, o_pc_ready back 1 cycle later.
REQ-039 Backpressure: ready=0 for 5 cycles -> o_instr, o_instr_pc and valid stable all 5 cycles, o_pc_ready=0; a new i_pc_valid during HOLD is ignored.
REQ-040 Memory stall: gnt delayed 3 cycles -> o_imem_req and o_imem_addr=0x104 stable for 4 cycles, one grant only.
REQ-041 Flush in WAIT, then rdata=0xDEADBEEF -> response dropped, o_instr_valid stays 0, next fetch at pc=0x200 returns its own data.
REQ-042 Async reset asserted in WAIT, between clock edges -> outputs at reset values before the next edge; a stray rvalid after release gives no o_instr_valid.
REQ-043 With FETCH_MISALIGN_CHECK_EN, pc=0x102 -> no o_imem_req, o_fault=1, o_instr_pc=0x102, o_instr_valid asserted 1 cycle after acceptance.
